// File: rtl/eth_tx_pktbuf.sv
// rtl/eth_tx_pktbuf.sv - store-and-forward TX frame buffer feeding the 10G MAC
module eth_tx_pktbuf #(
    parameter int DEPTH_LOG2 = 9,
    parameter int PKTS_LOG2  = 4
) (
    input  logic        clk156,
    input  logic        sys_rst156,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic [7:0]  s_axis_tkeep,
    input  logic [63:0] s_axis_tdata,
    output logic        m_axis_tx_tvalid,
    input  logic        m_axis_tx_tready,
    output logic        m_axis_tx_tlast,
    output logic [7:0]  m_axis_tx_tkeep,
    output logic [63:0] m_axis_tx_tdata,
    output logic        m_axis_tx_tuser,
    output logic [31:0] drop_count,
    output logic [31:0] tx_count
);
    localparam int W = 73;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef enum logic [1:0] {IDLE, LOAD, SEND} rd_state_t;

    logic [W-1:0]         mem [0:(1<<DEPTH_LOG2)-1];
    ptr_t                 wr_ptr, wr_ptr_tmp, rd_ptr;
    logic [PKTS_LOG2-1:0] pkt_cnt;
    logic                 ready_q, drop_mode, commit_q;
    logic [W-1:0]         ram_q, skid_q, out_q;
    logic                 rq_v, skid_v, out_v;
    rd_state_t            state, state_nxt;
    logic                 beat, ram_full, cnt_full, drop_now, wr_en;
    logic                 rd_en, pop, tx_done, can_read;
    logic [1:0]           occupancy;

    // Write-side decisions. The frame-count check includes a commit still in
    // flight, because pkt_cnt only picks it up one cycle after the tlast beat.
    assign beat      = s_axis_tvalid && ready_q;
    assign ram_full  = (wr_ptr_tmp + ptr_t'(1)) == rd_ptr;
    assign cnt_full  = ({1'b0, pkt_cnt} + {{PKTS_LOG2{1'b0}}, commit_q})
                       >= {1'b0, {PKTS_LOG2{1'b1}}};
    assign drop_now  = beat && !drop_mode && (ram_full || (s_axis_tlast && cnt_full));
    assign wr_en     = beat && !drop_mode && !drop_now;

    assign s_axis_tready = ready_q;

    // Ingress pointer management: speculative write pointer, commit on tlast,
    // rewind and discard the remainder of a dropped frame.
    always_ff @(posedge clk156) begin
        if (sys_rst156) begin
            ready_q    <= 1'b0;
            wr_ptr     <= '0;
            wr_ptr_tmp <= '0;
            drop_mode  <= 1'b0;
            commit_q   <= 1'b0;
            drop_count <= '0;
        end else begin
            ready_q  <= 1'b1;
            commit_q <= 1'b0;
            if (beat && drop_mode) begin
                if (s_axis_tlast) begin
                    drop_mode <= 1'b0;
                end
            end else if (drop_now) begin
                wr_ptr_tmp <= wr_ptr;
                drop_mode  <= !s_axis_tlast;
                if (drop_count != 32'hFFFF_FFFF) begin
                    drop_count <= drop_count + 32'd1;
                end
            end else if (wr_en) begin
                wr_ptr_tmp <= wr_ptr_tmp + ptr_t'(1);
                if (s_axis_tlast) begin
                    wr_ptr   <= wr_ptr_tmp + ptr_t'(1);
                    commit_q <= 1'b1;
                end
            end
        end
    end

    // Frame RAM: one write port, one registered read port.
    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem[wr_ptr_tmp] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr];
        end
    end

    // A read may be issued only if its word is guaranteed a slot in the
    // output/skid pair one cycle later, even if the MAC stalls meanwhile.
    assign pop       = out_v && m_axis_tx_tready;
    assign tx_done   = pop && out_q[72];
    assign occupancy = {1'b0, out_v} + {1'b0, skid_v} + {1'b0, rq_v};
    assign can_read  = (rd_ptr != wr_ptr) && ((occupancy - {1'b0, pop}) <= 2'd1);

    // Read FSM: next state and RAM read request.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_cnt != '0 && rd_ptr != wr_ptr) begin
                    rd_en     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                rd_en     = can_read;
                state_nxt = SEND;
            end
            SEND: begin
                rd_en = can_read;
                if (tx_done && !skid_v && !rq_v && !can_read) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read FSM state, read pointer, queued-frame count and sent-frame count.
    always_ff @(posedge clk156) begin
        if (sys_rst156) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            pkt_cnt  <= '0;
            tx_count <= '0;
        end else begin
            state   <= state_nxt;
            pkt_cnt <= pkt_cnt + {{(PKTS_LOG2-1){1'b0}}, commit_q}
                               - {{(PKTS_LOG2-1){1'b0}}, tx_done};
            if (rd_en) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            if (tx_done) begin
                tx_count <= tx_count + 32'd1;
            end
        end
    end

    // Output register with a one-word skid behind it; RAM data lands in the
    // output register when it is free, otherwise in the skid.
    always_ff @(posedge clk156) begin
        if (sys_rst156) begin
            out_v  <= 1'b0;
            out_q  <= '0;
            skid_v <= 1'b0;
            skid_q <= '0;
            rq_v   <= 1'b0;
        end else begin
            rq_v <= rd_en;
            if (!out_v || pop) begin
                if (skid_v) begin
                    out_q  <= skid_q;
                    out_v  <= 1'b1;
                    skid_v <= rq_v;
                    if (rq_v) begin
                        skid_q <= ram_q;
                    end
                end else if (rq_v) begin
                    out_q <= ram_q;
                    out_v <= 1'b1;
                end else begin
                    out_v <= 1'b0;
                end
            end else if (rq_v) begin
                skid_q <= ram_q;
                skid_v <= 1'b1;
            end
        end
    end

    // Network order in RAM, little-endian lane order toward the MAC.
    for (genvar i = 0; i < 8; i++) begin : g_lane
        assign m_axis_tx_tdata[8*i +: 8] = out_q[8*(7-i) +: 8];
        assign m_axis_tx_tkeep[i]        = out_q[64 + 7 - i];
    end

    assign m_axis_tx_tvalid = out_v;
    assign m_axis_tx_tlast  = out_q[72];
    assign m_axis_tx_tuser  = 1'b0;
endmodule
